// File: rtl/port_a_mode1_handshake_if.sv
// Port A handshake bus: CPU-side strobes and data, control word, and the Port A pin group.
// The master drives the inputs and the slave is the handshake engine.
interface port_a_mode1_handshake_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] CONTROL_WORD;
  logic              CW_WR;
  logic              BSR_WR;
  logic              RD_A;
  logic              WR_A;
  logic [DATA_W-1:0] DATA_IN;
  logic [DATA_W-1:0] DATA_OUT;
  logic [DATA_W-1:0] PA_IN;
  logic [DATA_W-1:0] PA_OUT;
  logic              PA_OE;
  logic              STB_N;
  logic              ACK_N;
  logic              IBF;
  logic              OBF_N;
  logic              INTR;
  logic              INTE;

  modport master (
    output CONTROL_WORD, CW_WR, BSR_WR, RD_A, WR_A, DATA_IN, PA_IN, STB_N, ACK_N,
    input  DATA_OUT, PA_OUT, PA_OE, IBF, OBF_N, INTR, INTE
  );

  modport slave (
    input  CONTROL_WORD, CW_WR, BSR_WR, RD_A, WR_A, DATA_IN, PA_IN, STB_N, ACK_N,
    output DATA_OUT, PA_OUT, PA_OE, IBF, OBF_N, INTR, INTE
  );
endinterface

// File: rtl/port_a_mode1_handshake.sv
// PPI Port A strobed-handshake engine (Mode 0 / Mode 1 input and output).
// Optional feature macro PA_HS_SYNC_EN: when defined, STB_N/ACK_N (and PA_IN)
// pass a 2-flop synchronizer before edge detection (3-cycle pin latency);
// otherwise pins must be synchronous to CLK (1-cycle pin latency).
module port_a_mode1_handshake #(
  parameter int unsigned DATA_W = 8
) (
  input logic                     CLK,
  input logic                     RESET_N,
  port_a_mode1_handshake_if.slave bus
);

  typedef enum logic [1:0] {
    IN_EMPTY  = 2'd0,
    IN_STROBE = 2'd1,
    IN_FULL   = 2'd2
  } in_state_e;

  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    OUT_FULL  = 2'd1,
    OUT_ACK   = 2'd2
  } out_state_e;

  localparam int unsigned SEL_W = 3;

  in_state_e         in_state_q,  in_state_d;
  out_state_e        out_state_q, out_state_d;

  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] pa_out_q,   pa_out_d;
  logic [DATA_W-1:0] latch_q,    latch_d;
  logic              pa_oe_q,    pa_oe_d;
  logic              ibf_q,      ibf_d;
  logic              obf_n_q,    obf_n_d;
  logic              intr_q,     intr_d;
  logic              inte_q,     inte_d;

  logic              stb_s_c, ack_s_c;
  logic [DATA_W-1:0] pa_s_c;
  logic              stb_prev_q, ack_prev_q;
  logic              stb_fall_c, stb_rise_c, ack_fall_c, ack_rise_c;

  logic              mode1_c, dir_in_c, in_act_c, out_act_c;
  logic [SEL_W-1:0]  bsr_sel_c;
  logic              inte_hit_c;
  logic              unused_c;

`ifdef PA_HS_SYNC_EN
  logic [1:0]        stb_sync_q, ack_sync_q;
  logic [DATA_W-1:0] pa_s1_q, pa_s2_q;

  // Two-flop synchronizers; PA_IN follows the same path so data stays aligned with STB_N
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stb_sync_q <= 2'b11;
      ack_sync_q <= 2'b11;
      pa_s1_q    <= '0;
      pa_s2_q    <= '0;
    end else begin
      stb_sync_q <= {stb_sync_q[0], bus.STB_N};
      ack_sync_q <= {ack_sync_q[0], bus.ACK_N};
      pa_s1_q    <= bus.PA_IN;
      pa_s2_q    <= pa_s1_q;
    end
  end

  assign stb_s_c = stb_sync_q[1];
  assign ack_s_c = ack_sync_q[1];
  assign pa_s_c  = pa_s2_q;
`else
  assign stb_s_c = bus.STB_N;
  assign ack_s_c = bus.ACK_N;
  assign pa_s_c  = bus.PA_IN;
`endif

  // Edge-detect flops on the sampled pin levels (idle high)
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stb_prev_q <= 1'b1;
      ack_prev_q <= 1'b1;
    end else begin
      stb_prev_q <= stb_s_c;
      ack_prev_q <= ack_s_c;
    end
  end

  assign stb_fall_c = stb_prev_q  & ~stb_s_c;
  assign stb_rise_c = ~stb_prev_q &  stb_s_c;
  assign ack_fall_c = ack_prev_q  & ~ack_s_c;
  assign ack_rise_c = ~ack_prev_q &  ack_s_c;

  // Control word decode; Mode 2 encodings fall through to Mode 0
  assign mode1_c   = bus.CONTROL_WORD[7] & (bus.CONTROL_WORD[6:5] == 2'b01);
  assign dir_in_c  = bus.CONTROL_WORD[4];
  assign in_act_c  = mode1_c &  dir_in_c;
  assign out_act_c = mode1_c & ~dir_in_c;

  // Port A INTE lives on PC4 in input mode and PC6 in output mode
  assign bsr_sel_c  = bus.DATA_IN[3:1];
  assign inte_hit_c = bus.BSR_WR & ~bus.DATA_IN[7] &
                      ((in_act_c  & (bsr_sel_c == SEL_W'(4))) |
                       (out_act_c & (bsr_sel_c == SEL_W'(6))));

  assign unused_c = ^bus.CONTROL_WORD[3:0];

  // FSM state registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      in_state_q  <= IN_EMPTY;
      out_state_q <= OUT_EMPTY;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
    end
  end

  // Next-state logic; pin edges are applied before CPU strobes
  always_comb begin
    in_state_d  = in_state_q;
    out_state_d = out_state_q;

    if (bus.CW_WR || !in_act_c) begin
      in_state_d = IN_EMPTY;
    end else begin
      case (in_state_q)
        IN_EMPTY, IN_FULL: begin
          if (stb_fall_c)      in_state_d = IN_STROBE;
          else if (bus.RD_A)   in_state_d = IN_EMPTY;
        end
        IN_STROBE: begin
          if (stb_rise_c)      in_state_d = IN_FULL;
          else if (bus.RD_A)   in_state_d = IN_EMPTY;
        end
        default:               in_state_d = IN_EMPTY;
      endcase
    end

    if (bus.CW_WR || !out_act_c) begin
      out_state_d = OUT_EMPTY;
    end else begin
      case (out_state_q)
        OUT_EMPTY: ;
        OUT_FULL:  if (ack_fall_c) out_state_d = OUT_ACK;
        OUT_ACK:   if (ack_rise_c) out_state_d = OUT_EMPTY;
        default:   out_state_d = OUT_EMPTY;
      endcase
      if (bus.WR_A) out_state_d = OUT_FULL;
    end
  end

  // Output next values: CW_WR > BSR > pin edge > CPU strobe
  always_comb begin
    data_out_d = data_out_q;
    pa_out_d   = pa_out_q;
    latch_d    = latch_q;
    pa_oe_d    = ~dir_in_c;
    ibf_d      = ibf_q;
    obf_n_d    = obf_n_q;
    intr_d     = intr_q;
    inte_d     = inte_q;

    if (!mode1_c) begin
      data_out_d = bus.PA_IN;
      if (bus.WR_A) pa_out_d = bus.DATA_IN;
      ibf_d   = 1'b0;
      obf_n_d = 1'b1;
      intr_d  = 1'b0;
    end

    if (bus.CW_WR) begin
      ibf_d    = 1'b0;
      obf_n_d  = 1'b1;
      intr_d   = 1'b0;
      inte_d   = 1'b0;
      pa_out_d = '0;
    end else begin
      if (inte_hit_c) inte_d = bus.DATA_IN[0];

      if (in_act_c) begin
        if ((in_state_q == IN_STROBE) && stb_rise_c) intr_d = inte_d;
        else if (bus.RD_A)                           intr_d = 1'b0;
        if (bus.RD_A) data_out_d = latch_q;
        // IBF drops one cycle after the read has emptied the FSM
        if (stb_fall_c && (in_state_q != IN_STROBE)) begin
          latch_d = pa_s_c;
          ibf_d   = 1'b1;
        end else if (in_state_q == IN_EMPTY) begin
          ibf_d   = 1'b0;
        end
      end

      if (out_act_c) begin
        if ((out_state_q == OUT_FULL) && ack_fall_c) obf_n_d = 1'b1;
        if ((out_state_q == OUT_ACK)  && ack_rise_c) intr_d  = inte_d;
        if (bus.WR_A) begin
          pa_out_d = bus.DATA_IN;
          obf_n_d  = 1'b0;
          intr_d   = 1'b0;
        end
      end

      if (!inte_d) intr_d = 1'b0;
    end
  end

  // Output and data registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      data_out_q <= '0;
      pa_out_q   <= '0;
      latch_q    <= '0;
      pa_oe_q    <= 1'b0;
      ibf_q      <= 1'b0;
      obf_n_q    <= 1'b1;
      intr_q     <= 1'b0;
      inte_q     <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      pa_out_q   <= pa_out_d;
      latch_q    <= latch_d;
      pa_oe_q    <= pa_oe_d;
      ibf_q      <= ibf_d;
      obf_n_q    <= obf_n_d;
      intr_q     <= intr_d;
      inte_q     <= inte_d;
    end
  end

  assign bus.DATA_OUT = data_out_q;
  assign bus.PA_OUT   = pa_out_q;
  assign bus.PA_OE    = pa_oe_q;
  assign bus.IBF      = ibf_q;
  assign bus.OBF_N    = obf_n_q;
  assign bus.INTR     = intr_q;
  assign bus.INTE     = inte_q;

endmodule

// File: doc/port_a_mode1_handshake.md
# port_a_mode1_handshake

Strobed-handshake engine for PPI Port A, sitting directly downstream of Control_Register and consuming the control word it holds. It decodes Mode 0 / Mode 1 and Port A direction from the control word. In Mode 1 it runs the input (STB/IBF/INTR) or output (OBF/ACK/INTR) handshake against the external pins and the CPU read/write strobes, and tracks the Port A interrupt-enable (INTE) bit via Port C bit set/reset commands.

## Interface
- DATA_W, 8, width of the CPU bus and Port A data path
- CLK  in  1  system clock; all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- CONTROL_WORD  in  DATA_W  current control word from Control_Register
- CW_WR  in  1  one-cycle pulse: a new mode-set word was just written
- BSR_WR  in  1  one-cycle pulse: a bit set/reset word is on DATA_IN
- RD_A  in  1  one-cycle CPU read pulse for Port A
- WR_A  in  1  one-cycle CPU write pulse for Port A
- DATA_IN  in  DATA_W  CPU write data / BSR word
- DATA_OUT  out  DATA_W  Port A read data to CPU
- PA_IN  in  DATA_W  Port A pins, input direction
- PA_OUT  out  DATA_W  Port A output latch
- PA_OE  out  1  1 = Port A drives pins
- STB_N  in  1  external strobe, active low (input mode)
- ACK_N  in  1  external acknowledge, active low (output mode)
- IBF  out  1  input buffer full
- OBF_N  out  1  output buffer full, active low
- INTR  out  1  Port A interrupt request
- INTE  out  1  Port A interrupt enable

## Operation
- Decode: MODE1 = CONTROL_WORD[7] & (CONTROL_WORD[6:5]==2'b01); DIR_IN = CONTROL_WORD[4]. Bits[6:5]=1x (Mode 2) are treated as Mode 0.
- Mode 0: PA_OE = ~DIR_IN; DATA_OUT = PA_IN sampled each cycle; WR_A loads PA_OUT. IBF=0, OBF_N=1, INTR=0.
- Input FSM (MODE1 & DIR_IN), states IN_EMPTY, IN_STROBE, IN_FULL:
  - IN_EMPTY/IN_FULL: STB_N falling edge -> latch PA_IN, IBF=1, go IN_STROBE.
  - IN_STROBE: STB_N rising edge -> INTR=INTE, go IN_FULL.
  - RD_A -> DATA_OUT = latch, INTR=0; IBF clears the cycle after RD_A; go IN_EMPTY.
- Output FSM (MODE1 & ~DIR_IN), states OUT_EMPTY, OUT_FULL, OUT_ACK:
  - WR_A -> PA_OUT=DATA_IN, OBF_N=0, INTR=0, go OUT_FULL.
  - OUT_FULL: ACK_N falling edge -> OBF_N=1, go OUT_ACK.
  - OUT_ACK: ACK_N rising edge -> INTR=INTE, go OUT_EMPTY.
- BSR (BSR_WR & ~DATA_IN[7]): bit select DATA_IN[3:1]. Select 4 (input mode) or 6 (output mode) sets INTE=DATA_IN[0]. Clearing INTE forces INTR=0. Other selects are ignored.
- CW_WR: FSMs return to EMPTY; IBF=0, OBF_N=1, INTR=0, INTE=0, PA_OUT=0.
- Priority within a cycle: RESET_N > CW_WR > BSR_WR > pin edge > CPU strobe.
  - RD_A coincident with STB_N falling: the new data is latched, IBF stays 1, and DATA_OUT returns the old latch.
  - WR_A in OUT_FULL/OUT_ACK: PA_OUT is overwritten, OBF_N=0, state returns to OUT_FULL, INTR=0.

## Timing
- Reset values: DATA_OUT=0, PA_OUT=0, PA_OE=0, IBF=0, OBF_N=1, INTR=0, INTE=0, FSMs in EMPTY.
- Reset is asynchronous. Asserting RESET_N mid-handshake aborts it immediately; no pending INTR survives.
- STB_N/ACK_N pass a 2-flop synchronizer plus an edge-detect flop. A pin edge affects outputs 3 CLK edges later.
- DATA_OUT, IBF, OBF_N and INTR are registered. CPU-strobe effects are visible 1 cycle after the strobe; IBF clear is visible 2 cycles after RD_A.
- PA_IN is captured from the synchronized-domain sample in the same cycle the falling STB_N edge is detected.
- Pin pulses shorter than 2 CLK periods are not guaranteed to be seen.

## Configuration
- PA_HS_SYNC_EN defined: the 2-flop synchronizers on STB_N/ACK_N are present; pin-to-output latency is 3 cycles.
- PA_HS_SYNC_EN undefined: pins are sampled by the edge-detect flop only; latency is 1 cycle; pins must already be synchronous to CLK.

## Test plan
- Reset: hold RESET_N=0 with random inputs -> IBF=0, OBF_N=1, INTR=0, INTE=0, PA_OUT=0, PA_OE=0.
- Input handshake: CW_WR with CONTROL_WORD=8'hB0, BSR 8'h09 (INTE=1), PA_IN=8'h5A, pulse STB_N low 4 cycles.
  - Expected: IBF=1 three cycles after the fall; INTR=1 three cycles after the rise.
  - Then RD_A -> DATA_OUT=8'h5A, INTR=0 next cycle, IBF=0 one cycle later.
- Output handshake: CONTROL_WORD=8'hA0, BSR 8'h0D, WR_A with DATA_IN=8'hC3.
  - Expected: PA_OUT=8'hC3, OBF_N=0, PA_OE=1.
  - ACK_N low then high -> OBF_N=1, then INTR=1.
- INTE gating: repeat the input handshake with BSR 8'h08 -> IBF behaves as before, INTR stays 0. A later BSR 8'h09 does not raise INTR retroactively.
- Mode 0: CONTROL_WORD=8'h80, WR_A with 8'h3C -> PA_OUT=8'h3C, PA_OE=1. STB_N toggling has no effect on IBF or INTR.
- Abort: CW_WR in IN_STROBE, or RESET_N=0 in OUT_FULL -> all flags return to their reset values and the next handshake completes normally.
